// File: rtl/serial_pattern_detector_if.sv
// Bundle of the pattern detector's control, serial data and status signals.
// Master: load, pattern_in, overlap_in, in_valid, x_in. Slave: OUT, match_cnt.
interface serial_pattern_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             load;
    logic [PAT_W-1:0] pattern_in;
    logic             overlap_in;
    logic             in_valid;
    logic             x_in;
    logic [1:0]       OUT;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output load, pattern_in, overlap_in, in_valid, x_in,
        input  OUT, match_cnt
    );

    modport slave (
        input  load, pattern_in, overlap_in, in_valid, x_in,
        output OUT, match_cnt
    );
endinterface

// File: rtl/serial_pattern_detector.sv
// Serial detector for a loadable PAT_W-bit pattern with a saturating counter.
// Ports: CLK, reset (sync, active-high), bus (slave): load/pattern/overlap in, bit stream in, OUT/match_cnt out.
module serial_pattern_detector #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                      CLK,
    input  logic                      reset,
    serial_pattern_detector_if.slave  bus
);
    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BIT  = 2'b01;
    localparam logic [1:0] ST_HIT  = 2'b10;
    localparam logic [1:0] ST_OVF  = 2'b11;

    logic [PAT_W-1:0] hist_q, hist_d, hist_n;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [FW-1:0]    fill_q, fill_d, fill_n;
    logic             ovl_q, ovl_d;
    logic [1:0]       out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    // fill counts accepted bits since the window was cleared; it gates the
    // compare so zero-filled history never counts as pattern bits.
    assign hist_n = {hist_q[PAT_W-2:0], bus.x_in};
    assign fill_n = (fill_q == FULL) ? FULL : fill_q + FW'(1);
    assign hit    = (fill_n == FULL) && (hist_n == pat_q);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        pat_d  = pat_q;
        ovl_d  = ovl_q;
        cnt_d  = cnt_q;
        out_d  = ST_IDLE;
        if (bus.load) begin
            pat_d  = bus.pattern_in;
            ovl_d  = bus.overlap_in;
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (bus.in_valid) begin
            hist_d = hist_n;
            if (hit) begin
                // Non-overlapping mode restarts the window after a match.
                fill_d = ovl_q ? FULL : '0;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    out_d = ST_HIT;
                end else begin
                    out_d = ST_OVF;
                end
            end else begin
                fill_d = fill_n;
                out_d  = ST_BIT;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            pat_q  <= '0;
            ovl_q  <= 1'b0;
            cnt_q  <= '0;
            out_q  <= ST_IDLE;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            pat_q  <= pat_d;
            ovl_q  <= ovl_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign bus.OUT       = out_q;
    assign bus.match_cnt = cnt_q;
endmodule
